bus_fifo_in: RTL and testbench

Per-device transmit FIFO between a device's traffic source and the shared bus arbiter. One instance is built per bus device, DRVRS instances in total. The source pushes packets into the FIFO. The bus pulls the head packet through a pending/pop handshake. The FIFO buffers bursts and reports overflow events.

---
 rtl/bus_fifo_in.sv | 140 ++++++++++++++
 tb/tb_bus_fifo_in.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_in.sv
// bus_fifo_in: per-device transmit FIFO sitting between a device's traffic
// source and the shared bus arbiter. The source pushes packets; the bus takes
// the head packet through a pending/pop handshake. The head word is shown
// first-word-fall-through on D_pop and forced to 0 while the FIFO is empty.
//
// Parameters:
//   WIDTH  packet width; destination ID lives in D_push[WIDTH-1:WIDTH-8]
//   DEPTH  number of entries (power of two, >= 2)
//   DRVRS  number of bus devices, used to validate the destination ID
//   ID     this device's bus ID (sending to yourself is flagged as bad)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   push      write request from the source, data on D_push
//   full      FIFO holds DEPTH entries
//   pop       read request from the bus
//   D_pop     head packet (0 when empty)
//   pndng     at least one packet pending
//   count     current occupancy
//   overflow  sticky: a push arrived while full without a matching pop
//   bad_dst   sticky: an accepted push had destination >= DRVRS or == ID
//   drop_cnt  number of overflow events, saturating at 255
//
// Build option:
//   FIFO_DROP_OLDEST_EN  when defined, a push while full (no pop) evicts the
//                        oldest entry instead of discarding the new packet.

module bus_fifo_in #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int DRVRS = 4,
  parameter int ID    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           D_push,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           D_pop,
  output logic                       pndng,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       bad_dst,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef FIFO_DROP_OLDEST_EN
  localparam logic DROP_OLDEST = 1'b1;
`else
  localparam logic DROP_OLDEST = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          bad_dst_reg, bad_dst_next;
  logic [7:0]    drop_cnt_reg, drop_cnt_next;

  logic          full_w, pndng_w;
  logic          ovf_evt, wr_en, rd_adv;
  logic [7:0]    dst;
  logic          dst_bad;

  assign full_w  = (count_reg == CW'(DEPTH));
  assign pndng_w = (count_reg != '0);

  // Destination check is widened by one bit so DRVRS up to 256 compares
  // correctly against the 8-bit destination field.
  assign dst     = D_push[WIDTH-1 -: 8];
  assign dst_bad = ({1'b0, dst} >= 9'(DRVRS)) || ({1'b0, dst} == 9'(ID));

  always_comb begin
    // A push while full is only an overflow when no pop frees a slot in the
    // same cycle; with a pop both operations simply proceed.
    ovf_evt = push && full_w && !pop;
    wr_en   = push && (!full_w || pop || DROP_OLDEST);
    // Read pointer moves on a real pop, or on eviction in drop-oldest mode.
    rd_adv  = (pop && pndng_w) || (ovf_evt && DROP_OLDEST);

    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    bad_dst_next  = bad_dst_reg;
    drop_cnt_next = drop_cnt_reg;

    if (wr_en)  wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_adv) rd_ptr_next = rd_ptr_reg + 1'b1;

    if (wr_en && !rd_adv)      count_next = count_reg + 1'b1;
    else if (rd_adv && !wr_en) count_next = count_reg - 1'b1;

    if (ovf_evt) begin
      overflow_next = 1'b1;
      if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
    end

    if (wr_en && dst_bad) bad_dst_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      bad_dst_reg  <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      bad_dst_reg  <= bad_dst_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage is not cleared by reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_ptr_reg] <= D_push;
  end

  assign full     = full_w;
  assign pndng    = pndng_w;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign bad_dst  = bad_dst_reg;
  assign drop_cnt = drop_cnt_reg;
  assign D_pop    = pndng_w ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_bus_fifo_in.sv
// Bench for bus_fifo_in: directed stimulus, a queue-based reference model
// checked every cycle, and literal expectations at key points.
module tb_bus_fifo_in;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic [WIDTH-1:0]  D_push = '0;
  logic              pop = 1'b0;
  logic              full;
  logic [WIDTH-1:0]  D_pop;
  logic              pndng;
  logic [3:0]        count;
  logic              overflow;
  logic              bad_dst;
  logic [7:0]        drop_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bus_fifo_in #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DRVRS(4), .ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .D_push(D_push), .full(full),
    .pop(pop), .D_pop(D_pop), .pndng(pndng), .count(count),
    .overflow(overflow), .bad_dst(bad_dst), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus sticky flags.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_bad;
  int               m_drops;

  function automatic bit is_bad(input logic [WIDTH-1:0] d);
    int dest;
    dest = int'(d[WIDTH-1:WIDTH-8]);
    return (dest >= 4) || (dest == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_bad = 0; m_drops = 0;
    end else begin
      int  sz;
      sz = q.size();
      if (pop && sz > 0) void'(q.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) begin
          q.push_back(D_push);
          if (is_bad(D_push)) m_bad = 1;
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
`ifdef FIFO_DROP_OLDEST_EN
          void'(q.pop_front());
          q.push_back(D_push);
          if (is_bad(D_push)) m_bad = 1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count",    32'(count),    32'(q.size()));
      check("m_pndng",    32'(pndng),    32'(q.size() != 0));
      check("m_full",     32'(full),     32'(q.size() == DEPTH));
      check("m_dpop",     32'(D_pop),    32'((q.size() != 0) ? q[0] : 16'h0000));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_bad_dst",  32'(bad_dst),  32'(m_bad));
      check("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic r, input logic p, input logic [WIDTH-1:0] d, input logic o);
    rst_n = r; push = p; D_push = d; pop = o;
    $display("txn t=%0t rst_n=%0b push=%0b d=%04h pop=%0b", $time, r, p, d, o);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_w;
    #1;
    // Reset then idle
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_pndng", 32'(pndng), 0);
    check("rst_full", 32'(full), 0);
    check("rst_dpop", 32'(D_pop), 32'h0000);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);

    // Fill then drain
    cyc(1'b1, 1'b1, 16'h0100, 1'b0);
    check("lat_pndng", 32'(pndng), 1);
    check("lat_dpop", 32'(D_pop), 32'h0100);
    for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      check("drain_dpop", 32'(D_pop), 32'h0100 + i);
      cyc(1'b1, 1'b0, '0, 1'b1);
    end
    check("drain_pndng", 32'(pndng), 0);
    check("drain_dpop_zero", 32'(D_pop), 0);
    cyc(1'b1, 1'b0, '0, 1'b1);  // pop while empty is ignored
    check("empty_pop_count", 32'(count), 0);

    // Overflow while full, no pop
    fill8();
    cyc(1'b1, 1'b1, 16'h03AA, 1'b0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drop_cnt", 32'(drop_cnt), 1);
    check("ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_DROP_OLDEST_EN
      exp_w = (i < 7) ? 16'h0101 + 16'(i) : 16'h03AA;
`else
      exp_w = 16'h0100 + 16'(i);
`endif
      check("ovf_drain", 32'(D_pop), 32'(exp_w));
      cyc(1'b1, 1'b0, '0, 1'b1);
    end
    check("ovf_drain_pndng", 32'(pndng), 0);

    // Push and pop together while empty
    cyc(1'b1, 1'b1, 16'h0201, 1'b1);
    check("pp_empty_count", 32'(count), 1);
    check("pp_empty_dpop", 32'(D_pop), 32'h0201);
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Push and pop together while full, from a clean reset
    cyc(1'b0, 1'b0, '0, 1'b0);
    fill8();
    cyc(1'b1, 1'b1, 16'h0208, 1'b1);
    check("pp_full_count", 32'(count), 8);
    check("pp_full_overflow", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 7) ? 16'h0101 + 16'(i) : 16'h0208;
      check("pp_full_drain", 32'(D_pop), 32'(exp_w));
      cyc(1'b1, 1'b0, '0, 1'b1);
    end

    // Back-to-back streaming with one word in flight
    cyc(1'b1, 1'b1, 16'h0110, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 16'h0111 + 16'(i), 1'b1);
      check("stream_dpop", 32'(D_pop), 32'h0111 + i);
      check("stream_count", 32'(count), 1);
    end
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Bad destination, then reset mid-burst (push during reset ignored)
    cyc(1'b1, 1'b1, 16'h0500, 1'b0);
    check("bad_dst_set", 32'(bad_dst), 1);
    check("bad_dst_stored", 32'(D_pop), 32'h0500);
    cyc(1'b1, 1'b1, 16'h0101, 1'b0);
    cyc(1'b1, 1'b1, 16'h0102, 1'b0);
    cyc(1'b1, 1'b1, 16'h0103, 1'b0);
    check("burst_count", 32'(count), 4);
    cyc(1'b0, 1'b1, 16'h0104, 1'b1);
    check("midrst_count", 32'(count), 0);
    check("midrst_bad_dst", 32'(bad_dst), 0);
    check("midrst_pndng", 32'(pndng), 0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    check("post_rst_count", 32'(count), 0);

    // Sending to own ID is also a bad destination
    cyc(1'b1, 1'b1, 16'h00FF, 1'b0);
    check("own_id_bad_dst", 32'(bad_dst), 1);
    cyc(1'b1, 1'b0, '0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
